// File: rtl/coeff_store_wbs.sv
// Coefficient store: 512 x 64-bit entries held as four 16-bit lane banks.
// Serves the biquad fetch port, the 16-bit host port and the commit handshake.

module coeff_bank #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] radr,
  output logic [W-1:0]  rdat
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[wadr] <= wdat;

  assign rdat = mem[radr];
endmodule

module coeff_store_wbs #(
  parameter int DEPTH = 512
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     coeff_wbs_cyc_i,
  input  logic                     coeff_wbs_stb_i,
  input  logic [$clog2(DEPTH)-1:0] coeff_wbs_adr_i,
  output logic [63:0]              coeff_wbs_dat_o,
  output logic                     coeff_wbs_ack_o,
  input  logic                     host_wbs_cyc_i,
  input  logic                     host_wbs_stb_i,
  input  logic                     host_wbs_we_i,
  input  logic [11:0]              host_wbs_adr_i,
  input  logic [15:0]              host_wbs_dat_i,
  output logic [15:0]              host_wbs_dat_o,
  output logic                     host_wbs_ack_o,
  output logic                     load_new_coefficients,
  input  logic                     done_loading
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 16;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  state_t state, state_nxt;
  logic busy, commit_q, done_r, ovr_r;
  logic set_done, set_ovr, commit_go;

  logic coeff_fire, host_req, is_mem;
  logic mem_wr, mem_rd, reg_acc, host_fire;
  logic ctrl_sel, stat_sel, commit, stat_rd;
  logic [AW-1:0] host_entry, rd_adr;
  logic [1:0]    host_lane;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_word;

  assign busy       = (state != IDLE);
  assign coeff_fire = coeff_wbs_cyc_i & coeff_wbs_stb_i & ~coeff_wbs_ack_o;
  assign host_req   = host_wbs_cyc_i & host_wbs_stb_i & ~host_wbs_ack_o;
  assign is_mem     = ~host_wbs_adr_i[11];
  assign host_entry = host_wbs_adr_i[AW+1:2];
  assign host_lane  = host_wbs_adr_i[1:0];

  // Writes have their own port but wait out a commit; reads yield to fetches.
  assign mem_wr    = host_req & is_mem &  host_wbs_we_i & ~busy;
  assign mem_rd    = host_req & is_mem & ~host_wbs_we_i & ~coeff_fire;
  assign reg_acc   = host_req & ~is_mem;
  assign host_fire = mem_wr | mem_rd | reg_acc;

  assign ctrl_sel = (host_wbs_adr_i == 12'h800);
  assign stat_sel = (host_wbs_adr_i == 12'h801);
  assign commit   = reg_acc &  host_wbs_we_i & ctrl_sel & host_wbs_dat_i[0];
  assign stat_rd  = reg_acc & ~host_wbs_we_i & stat_sel;

  assign rd_adr = coeff_fire ? coeff_wbs_adr_i : host_entry;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    coeff_bank #(.DEPTH(DEPTH), .AW(AW), .W(LANE_W)) u_bank (
      .clk  (wb_clk_i),
      .we   (mem_wr & wb_rst_i & (host_lane == 2'(l))),
      .wadr (host_entry),
      .wdat (host_wbs_dat_i),
      .radr (rd_adr),
      .rdat (rd_word[l])
    );
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      coeff_wbs_ack_o <= 1'b0;
      coeff_wbs_dat_o <= '0;
      host_wbs_ack_o  <= 1'b0;
      host_wbs_dat_o  <= '0;
      commit_q        <= 1'b0;
      done_r          <= 1'b0;
      ovr_r           <= 1'b0;
    end else begin
      coeff_wbs_ack_o <= coeff_fire;
      if (coeff_fire) coeff_wbs_dat_o <= rd_word;
      host_wbs_ack_o <= host_fire;
      if (mem_rd)
        host_wbs_dat_o <= rd_word[host_lane];
      else if (stat_rd)
        host_wbs_dat_o <= {13'b0, ovr_r, done_r, busy};
      else if (reg_acc & ~host_wbs_we_i)
        host_wbs_dat_o <= '0;
      // The FSM acts on the commit one cycle after its ack.
      commit_q <= commit;
      // Setting wins over a STATUS read landing on the same edge.
      if (set_done)                 done_r <= 1'b1;
      else if (commit_go | stat_rd) done_r <= 1'b0;
      if (set_ovr)      ovr_r <= 1'b1;
      else if (stat_rd) ovr_r <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt             = state;
    load_new_coefficients = 1'b0;
    set_done              = 1'b0;
    set_ovr               = 1'b0;
    commit_go             = 1'b0;
    case (state)
      IDLE: if (commit_q) begin
        state_nxt = PULSE;
        commit_go = 1'b1;
      end
      PULSE: begin
        load_new_coefficients = 1'b1;
        set_ovr               = commit_q;
        state_nxt             = WAIT;
      end
      WAIT: begin
        set_ovr = commit_q;
        if (done_loading) begin
          state_nxt = IDLE;
          set_done  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_coeff_store_wbs.sv
// Directed bench for coeff_store_wbs: lanes, arbitration, commit/overrun, burst fetch, reset.

module tb_coeff_store_wbs;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        coeff_wbs_cyc_i = 1'b0, coeff_wbs_stb_i = 1'b0;
  logic [8:0]  coeff_wbs_adr_i = '0;
  logic [63:0] coeff_wbs_dat_o;
  logic        coeff_wbs_ack_o;
  logic        host_wbs_cyc_i = 1'b0, host_wbs_stb_i = 1'b0, host_wbs_we_i = 1'b0;
  logic [11:0] host_wbs_adr_i = '0;
  logic [15:0] host_wbs_dat_i = '0;
  logic [15:0] host_wbs_dat_o;
  logic        host_wbs_ack_o;
  logic        load_new_coefficients;
  logic        done_loading = 1'b0;

  int checks = 0, errors = 0;
  int load_cnt = 0;

  coeff_store_wbs #(.DEPTH(512)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .coeff_wbs_cyc_i(coeff_wbs_cyc_i), .coeff_wbs_stb_i(coeff_wbs_stb_i),
    .coeff_wbs_adr_i(coeff_wbs_adr_i), .coeff_wbs_dat_o(coeff_wbs_dat_o),
    .coeff_wbs_ack_o(coeff_wbs_ack_o),
    .host_wbs_cyc_i(host_wbs_cyc_i), .host_wbs_stb_i(host_wbs_stb_i),
    .host_wbs_we_i(host_wbs_we_i), .host_wbs_adr_i(host_wbs_adr_i),
    .host_wbs_dat_i(host_wbs_dat_i), .host_wbs_dat_o(host_wbs_dat_o),
    .host_wbs_ack_o(host_wbs_ack_o),
    .load_new_coefficients(load_new_coefficients), .done_loading(done_loading)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) if (load_new_coefficients) load_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [63:0] exp_word(input int i);
    logic [15:0] base;
    base = 16'((i + 1) * 16'h1000);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  task automatic host_xfer(input logic we, input logic [11:0] adr, input logic [15:0] wd,
                           output logic [15:0] rd, output int lat);
    host_wbs_cyc_i = 1'b1; host_wbs_stb_i = 1'b1;
    host_wbs_we_i = we; host_wbs_adr_i = adr; host_wbs_dat_i = wd;
    lat = -1; rd = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (host_wbs_ack_o) begin lat = i; rd = host_wbs_dat_o; break; end
    end
    host_wbs_cyc_i = 1'b0; host_wbs_stb_i = 1'b0; host_wbs_we_i = 1'b0;
    tick();
  endtask

  task automatic coeff_fetch(input logic [8:0] adr, output logic [63:0] d, output int lat);
    coeff_wbs_cyc_i = 1'b1; coeff_wbs_stb_i = 1'b1; coeff_wbs_adr_i = adr;
    lat = -1; d = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (coeff_wbs_ack_o) begin lat = i; d = coeff_wbs_dat_o; break; end
    end
    coeff_wbs_cyc_i = 1'b0; coeff_wbs_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [63:0] d;
    int lat, nack, acks, lc0;

    repeat (3) tick();
    chk("rst_coeff_ack", 64'(coeff_wbs_ack_o), 64'd0);
    chk("rst_host_ack", 64'(host_wbs_ack_o), 64'd0);
    chk("rst_load", 64'(load_new_coefficients), 64'd0);
    chk("rst_coeff_dat", coeff_wbs_dat_o, 64'd0);
    chk("rst_host_dat", 64'(host_wbs_dat_o), 64'd0);
    wb_rst_i = 1'b1;
    tick();

    // Reset asserted while a fetch is being acknowledged.
    coeff_wbs_cyc_i = 1'b1; coeff_wbs_stb_i = 1'b1; coeff_wbs_adr_i = 9'd7;
    tick();
    chk("midrst_ack_before", 64'(coeff_wbs_ack_o), 64'd1);
    wb_rst_i = 1'b0;
    #1;
    chk("midrst_ack", 64'(coeff_wbs_ack_o), 64'd0);
    chk("midrst_load", 64'(load_new_coefficients), 64'd0);
    chk("midrst_dat", coeff_wbs_dat_o, 64'd0);
    coeff_wbs_cyc_i = 1'b0; coeff_wbs_stb_i = 1'b0;
    tick();
    wb_rst_i = 1'b1;
    tick();
    host_xfer(1'b0, 12'h801, 16'h0, rd, lat);
    chk("midrst_status", 64'(rd), 64'h0);

    // Lane writes to entry 5.
    host_xfer(1'b1, 12'h014, 16'hEEEE, rd, lat);
    chk("lane_wr_lat", 64'(lat), 64'd1);
    host_xfer(1'b1, 12'h015, 16'hEEEE, rd, lat);
    host_xfer(1'b1, 12'h016, 16'hDDDD, rd, lat);
    host_xfer(1'b1, 12'h017, 16'hDDDD, rd, lat);
    coeff_fetch(9'd5, d, lat);
    chk("lane_fetch_dat", d, 64'hDDDDDDDDEEEEEEEE);
    chk("lane_fetch_lat", 64'(lat), 64'd1);

    // Same-cycle host read and fetch: fetch wins, host deferred one cycle.
    host_wbs_cyc_i = 1'b1; host_wbs_stb_i = 1'b1; host_wbs_we_i = 1'b0; host_wbs_adr_i = 12'h017;
    coeff_wbs_cyc_i = 1'b1; coeff_wbs_stb_i = 1'b1; coeff_wbs_adr_i = 9'd5;
    tick();
    chk("arb_coeff_ack", 64'(coeff_wbs_ack_o), 64'd1);
    chk("arb_coeff_dat", coeff_wbs_dat_o, 64'hDDDDDDDDEEEEEEEE);
    chk("arb_host_ack1", 64'(host_wbs_ack_o), 64'd0);
    coeff_wbs_cyc_i = 1'b0; coeff_wbs_stb_i = 1'b0;
    tick();
    chk("arb_host_ack2", 64'(host_wbs_ack_o), 64'd1);
    chk("arb_host_dat", 64'(host_wbs_dat_o), 64'hDDDD);
    host_wbs_cyc_i = 1'b0; host_wbs_stb_i = 1'b0;
    tick();

    // Fill entries 0..3 for the burst fetch.
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < 4; l++)
        host_xfer(1'b1, 12'(i * 4 + l), 16'((i + 1) * 16'h1000 + l), rd, lat);

    // Commit handshake with exact pulse timing.
    lc0 = load_cnt;
    host_wbs_cyc_i = 1'b1; host_wbs_stb_i = 1'b1; host_wbs_we_i = 1'b1;
    host_wbs_adr_i = 12'h800; host_wbs_dat_i = 16'h0001;
    tick();
    chk("commit_ack", 64'(host_wbs_ack_o), 64'd1);
    chk("commit_load_at_ack", 64'(load_new_coefficients), 64'd0);
    host_wbs_cyc_i = 1'b0; host_wbs_stb_i = 1'b0; host_wbs_we_i = 1'b0;
    tick();
    chk("commit_load_pulse", 64'(load_new_coefficients), 64'd1);
    tick();
    chk("commit_load_after", 64'(load_new_coefficients), 64'd0);
    host_xfer(1'b0, 12'h801, 16'h0, rd, lat);
    chk("commit_status_busy", 64'(rd), 64'h1);
    repeat (50) tick();
    chk("commit_load_count", 64'(load_cnt - lc0), 64'd1);
    done_loading = 1'b1;
    tick();
    done_loading = 1'b0;
    host_xfer(1'b0, 12'h801, 16'h0, rd, lat);
    chk("commit_status_done", 64'(rd), 64'h2);
    host_xfer(1'b0, 12'h801, 16'h0, rd, lat);
    chk("commit_status_clr", 64'(rd), 64'h0);

    // Busy stall of a memory write, plus overrun from a second commit.
    host_xfer(1'b1, 12'h800, 16'h0001, rd, lat);
    tick();
    host_wbs_cyc_i = 1'b1; host_wbs_stb_i = 1'b1; host_wbs_we_i = 1'b1;
    host_wbs_adr_i = 12'h014; host_wbs_dat_i = 16'hBBBB;
    acks = 0;
    repeat (5) begin tick(); if (host_wbs_ack_o) acks++; end
    chk("stall_no_ack", 64'(acks), 64'd0);
    host_wbs_cyc_i = 1'b0; host_wbs_stb_i = 1'b0; host_wbs_we_i = 1'b0;
    tick();
    host_xfer(1'b1, 12'h800, 16'h0001, rd, lat);
    chk("ovr_ctrl_lat", 64'(lat), 64'd1);
    host_wbs_cyc_i = 1'b1; host_wbs_stb_i = 1'b1; host_wbs_we_i = 1'b1;
    host_wbs_adr_i = 12'h014; host_wbs_dat_i = 16'hBBBB;
    repeat (3) tick();
    done_loading = 1'b1;
    tick();
    done_loading = 1'b0;
    chk("stall_ack_at_done", 64'(host_wbs_ack_o), 64'd0);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (host_wbs_ack_o) begin lat = i; break; end
    end
    chk("stall_release_lat", 64'(lat), 64'd1);
    host_wbs_cyc_i = 1'b0; host_wbs_stb_i = 1'b0; host_wbs_we_i = 1'b0;
    tick();
    coeff_fetch(9'd5, d, lat);
    chk("stall_fetch_dat", d, 64'hDDDDDDDDEEEEBBBB);
    host_xfer(1'b0, 12'h801, 16'h0, rd, lat);
    chk("ovr_status", 64'(rd), 64'h6);

    // Held strobe over entries 0..3: one ack every two cycles.
    coeff_wbs_cyc_i = 1'b1; coeff_wbs_stb_i = 1'b1; coeff_wbs_adr_i = 9'd0;
    nack = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (coeff_wbs_ack_o) begin
        chk("burst_dat", coeff_wbs_dat_o, exp_word(nack));
        chk("burst_spacing", 64'(c), 64'(2 * nack + 1));
        nack++;
        coeff_wbs_adr_i = 9'(nack);
      end
    end
    coeff_wbs_cyc_i = 1'b0; coeff_wbs_stb_i = 1'b0;
    tick();
    chk("burst_count", 64'(nack), 64'd4);

    // Unmapped register space and CTRL readback.
    host_xfer(1'b0, 12'h900, 16'h0, rd, lat);
    chk("unmapped_rd", 64'(rd), 64'h0);
    chk("unmapped_lat", 64'(lat), 64'd1);
    host_xfer(1'b0, 12'h800, 16'h0, rd, lat);
    chk("ctrl_rd", 64'(rd), 64'h0);
    host_xfer(1'b1, 12'hFFF, 16'h0001, rd, lat);
    chk("unmapped_wr_lat", 64'(lat), 64'd1);
    tick();
    host_xfer(1'b0, 12'h801, 16'h0, rd, lat);
    chk("unmapped_wr_no_commit", 64'(rd), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
